// File: rtl/stage_fetch.sv
// Instruction fetch stage: PC register, one imem read per instruction, single-entry output register.
// Optional build macro FETCH_PERF_CNT_EN adds saturating fetch/kill performance counters.
module stage_fetch #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000,
  parameter logic [31:0] PC_STEP  = 32'd4
) (
  input  logic        clk,
  input  logic        rst,
`ifdef FETCH_PERF_CNT_EN
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_kill_cnt,
`endif
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_inst,
  output logic [31:0] out_pc
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_OUT} state_e;

  state_e      state_q;
  logic [31:0] pc_q;
  logic        kill_q;
  logic        req_valid_q;
  logic        out_valid_q;
  logic [31:0] out_inst_q;
  logic [31:0] out_pc_q;

  logic req_fire_c;
  logic discard_c;

  assign req_fire_c = req_valid_q && imem_req_ready;
  assign discard_c  = (state_q == S_WAIT) && imem_rsp_valid && (kill_q || redirect_valid);

  assign imem_req_valid = req_valid_q;
  assign imem_req_addr  = pc_q;
  assign out_valid      = out_valid_q;
  assign out_inst       = out_inst_q;
  assign out_pc         = out_pc_q;

  // Fetch control: req_valid_q tracks S_REQ so the request is a registered output.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      pc_q        <= RESET_PC;
      kill_q      <= 1'b0;
      req_valid_q <= 1'b0;
      out_valid_q <= 1'b0;
      out_inst_q  <= 32'd0;
      out_pc_q    <= 32'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_q     <= S_REQ;
          req_valid_q <= 1'b1;
        end
        S_REQ: begin
          if (redirect_valid) pc_q <= redirect_pc;
          if (req_fire_c) begin
            state_q     <= S_WAIT;
            req_valid_q <= 1'b0;
            kill_q      <= redirect_valid;
          end
        end
        S_WAIT: begin
          if (redirect_valid) pc_q <= redirect_pc;
          if (imem_rsp_valid) begin
            kill_q <= 1'b0;
            if (discard_c) begin
              state_q     <= S_REQ;
              req_valid_q <= 1'b1;
            end else begin
              state_q     <= S_OUT;
              out_valid_q <= 1'b1;
              out_inst_q  <= imem_rsp_data;
              out_pc_q    <= pc_q;
            end
          end else if (redirect_valid) begin
            kill_q <= 1'b1;
          end
        end
        S_OUT: begin
          // A redirect wins the next PC even when decode takes the instruction.
          if (redirect_valid || out_ready) begin
            state_q     <= S_REQ;
            req_valid_q <= 1'b1;
            out_valid_q <= 1'b0;
            pc_q        <= redirect_valid ? redirect_pc : pc_q + PC_STEP;
          end
        end
      endcase
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic out_fire_c;
  logic squash_c;

  assign out_fire_c = out_valid_q && out_ready;
  assign squash_c   = (state_q == S_OUT) && redirect_valid && !out_ready;

  // Saturating event counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_fetch_cnt <= 32'd0;
      perf_kill_cnt  <= 32'd0;
    end else begin
      if (out_fire_c && perf_fetch_cnt != 32'hFFFF_FFFF)
        perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
      if ((discard_c || squash_c) && perf_kill_cnt != 32'hFFFF_FFFF)
        perf_kill_cnt <= perf_kill_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_stage_fetch.sv
// Bench for stage_fetch: directed scenarios then random traffic against a transaction-level model.
// Builds with or without FETCH_PERF_CNT_EN.
module tb_stage_fetch;

  localparam logic [31:0] RST_PC = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic [31:0] out_pc;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetch_cnt;
  logic [31:0] perf_kill_cnt;
`endif

  stage_fetch dut (
    .clk            (clk),
    .rst            (rst),
`ifdef FETCH_PERF_CNT_EN
    .perf_fetch_cnt (perf_fetch_cnt),
    .perf_kill_cnt  (perf_kill_cnt),
`endif
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_inst       (out_inst),
    .out_pc         (out_pc)
  );

  always #5 clk = ~clk;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  // Reference model: expected fetch address, handshake expectations, one outstanding memory read.
  logic [31:0] exp_pc;
  bit          exp_req;
  bit          exp_out;
  logic [31:0] exp_inst;
  bit          pend;
  bit          pend_kill;
  int          pend_cnt;
  logic [31:0] pend_addr;
  int          lat;
  bit          force_en;
  logic [31:0] force_data;
  logic [31:0] n_fetch;
  logic [31:0] n_kill;

  // Distinct addresses give distinct words (odd multiplier is a bijection); 0x13 at RESET_PC.
  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return ((a - RST_PC) * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    chk("req_valid", 32'(imem_req_valid), 32'(exp_req));
    if (exp_req) chk("req_addr", imem_req_addr, exp_pc);
    chk("out_valid", 32'(out_valid), 32'(exp_out));
    if (exp_out) begin
      chk("out_pc", out_pc, exp_pc);
      chk("out_inst", out_inst, exp_inst);
    end
`ifdef FETCH_PERF_CNT_EN
    chk("perf_fetch", perf_fetch_cnt, n_fetch);
    chk("perf_kill", perf_kill_cnt, n_kill);
`endif
  endtask

  // One clock: check at negedge, drive inputs, advance the model to the next posedge.
  task automatic step(input bit rdy, input bit ordy, input bit redir, input logic [31:0] rpc);
    bit          o, fire, hs, rsp;
    logic [31:0] d;
    @(negedge clk);
    check_outputs();
    o    = exp_out;
    fire = exp_req && rdy;
    hs   = o && ordy;
    rsp  = 1'b0;
    d    = $urandom;
    if (pend) begin
      pend_cnt--;
      if (pend_cnt == 0) begin
        rsp = 1'b1;
        d   = force_en ? force_data : mem_data(pend_addr);
      end
    end
    imem_req_ready = rdy;
    out_ready      = ordy;
    redirect_valid = redir;
    redirect_pc    = rpc;
    imem_rsp_valid = rsp;
    imem_rsp_data  = d;
    if (o && (ordy || redir)) begin
      exp_out = 1'b0;
      exp_req = 1'b1;
      if (hs) n_fetch++;
      else n_kill++;
    end
    if (rsp) begin
      pend = 1'b0;
      if (!pend_kill && !redir) begin
        exp_out  = 1'b1;
        exp_inst = d;
      end else begin
        exp_req = 1'b1;
        n_kill++;
      end
    end
    if (fire) begin
      pend      = 1'b1;
      pend_cnt  = lat;
      pend_addr = exp_pc;
      pend_kill = redir;
      exp_req   = 1'b0;
    end else if (pend && redir) begin
      pend_kill = 1'b1;
    end
    if (redir) exp_pc = rpc;
    else if (hs) exp_pc = exp_pc + 32'd4;
  endtask

  task automatic do_reset(input bit stale);
    @(negedge clk);
    rst = 1'b1;
    imem_req_ready = 1'b0; out_ready = 1'b0; redirect_valid = 1'b0;
    redirect_pc = 32'd0; imem_rsp_valid = 1'b0; imem_rsp_data = 32'd0;
    #1;
    chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_pc", out_pc, 32'd0);
    chk("rst_out_inst", out_inst, 32'd0);
`ifdef FETCH_PERF_CNT_EN
    chk("rst_perf_fetch", perf_fetch_cnt, 32'd0);
    chk("rst_perf_kill", perf_kill_cnt, 32'd0);
`endif
    @(negedge clk);
    rst = 1'b0;
    imem_rsp_valid = stale;
    imem_rsp_data  = 32'hDEAD_BEEF;
    exp_pc = RST_PC; exp_req = 1'b1; exp_out = 1'b0; exp_inst = 32'd0;
    pend = 1'b0; pend_kill = 1'b0; pend_cnt = 0; pend_addr = 32'd0;
    n_fetch = 32'd0; n_kill = 32'd0;
  endtask

  initial begin
    rst = 1'b1;
    lat = 1; force_en = 1'b0; force_data = 32'd0;
    do_reset(1'b0);

    // First fetch: REQ, WAIT, OUT with zero-wait memory.
    step(1'b1, 1'b0, 1'b0, 32'd0);
    chk("first_req_addr", imem_req_addr, 32'h8000_0000);
    step(1'b1, 1'b0, 1'b0, 32'd0);
    chk("first_wait_no_out", 32'(out_valid), 32'd0);
    step(1'b0, 1'b1, 1'b0, 32'd0);
    chk("first_out_pc", out_pc, 32'h8000_0000);
    chk("first_out_inst", out_inst, 32'h0000_0013);

    // Three more back-to-back fetches.
    for (int i = 1; i < 4; i++) begin
      step(1'b1, 1'b1, 1'b0, 32'd0);
      step(1'b1, 1'b1, 1'b0, 32'd0);
      step(1'b1, 1'b1, 1'b0, 32'd0);
      chk("seq_out_pc", out_pc, RST_PC + 32'(4 * i));
      chk("seq_out_inst", out_inst, mem_data(RST_PC + 32'(4 * i)));
    end

    // Decode stalls five cycles, then takes the instruction together with a redirect.
    step(1'b1, 1'b0, 1'b0, 32'd0);
    step(1'b1, 1'b0, 1'b0, 32'd0);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b0, 1'b0, 32'd0);
      chk("stall_out_pc", out_pc, 32'h8000_0010);
      chk("stall_no_req", 32'(imem_req_valid), 32'd0);
    end
    step(1'b1, 1'b1, 1'b1, 32'h8000_0040);
    lat = 3;
    step(1'b1, 1'b0, 1'b0, 32'd0);
    chk("redir_out_next_addr", imem_req_addr, 32'h8000_0040);

    // Redirect while waiting; the late response must be dropped.
    step(1'b0, 1'b0, 1'b1, 32'h8000_0100);
    force_en = 1'b1; force_data = 32'hDEAD_BEEF;
    step(1'b0, 1'b0, 1'b0, 32'd0);
    step(1'b0, 1'b0, 1'b0, 32'd0);
    force_en = 1'b0;
    step(1'b1, 1'b0, 1'b0, 32'd0);
    chk("kill_no_out", 32'(out_valid), 32'd0);
    chk("kill_next_addr", imem_req_addr, 32'h8000_0100);

    // Reset while waiting, stale response during idle.
    step(1'b0, 1'b0, 1'b0, 32'd0);
    do_reset(1'b1);
    step(1'b0, 1'b0, 1'b0, 32'd0);
    chk("post_rst_addr", imem_req_addr, 32'h8000_0000);
    chk("post_rst_out", 32'(out_valid), 32'd0);

    // Random traffic, including wrap-around redirects and a mid-run reset.
    for (int i = 0; i < 2000; i++) begin
      logic [31:0] rpc;
      if (i == 1000) do_reset(1'b1);
      lat = $urandom_range(1, 3);
      rpc = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF8 : 32'($urandom);
      step($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
           $urandom_range(0, 9) == 0, rpc);
    end
    @(negedge clk);
    check_outputs();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
